nexys_starship_btm_spawner: RTL and testbench
=============================================

// Module: nexys_starship_btm_spawner
// PURPOSE
//  Upstream monster source for the bottom station FSM. After play starts, waits a pseudo-random
//  delay, raises btm_monster_ctrl (consumed by the bottom-station FSM), and holds it until the
//  player kills the monster. If the monster survives ATTACK_TICKS, flags a timeout (drives
//  btm_broken / game-over logic). Stops permanently on an external game stop.
// PARAMETERS
//  TICK_DIV      100000   Clk cycles per tick (1 ms @ 100 MHz); >=1
//  DELAY_MIN     1000     minimum spawn delay, ticks; >=1
//  DELAY_MASK    16'h0FFF random delay add-on = lfsr & DELAY_MASK
//  ATTACK_TICKS  5000     ticks a monster may live before timeout; >=1
//  LFSR_SEED     16'hACE1 LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//  Clk                 in   1  clock
//  Reset               in   1  asynchronous, active-high reset
//  play_flag           in   1  level; leaves IDLE when high
//  game_stop           in   1  level; global game over, forces HALT
//  btm_kill            in   1  player shot the bottom monster (1-cycle pulse or level)
//  btm_monster_ctrl    out  1  monster present request to bottom-station FSM
//  btm_attack_timeout  out  1  sticky: monster outlived ATTACK_TICKS
//  kill_count          out  8  monsters killed, saturates at 255
//  q_Idle,q_Wait,q_Active,q_Halt out 1 each  one-hot state
// BEHAVIOUR
//  Reset: state=IDLE, btm_monster_ctrl=0, btm_attack_timeout=0, kill_count=0,
//   lfsr=LFSR_SEED, prescaler=0, delay_cnt=0, attack_cnt=0. All outputs registered.
//  LFSR: 16-bit Galois, mask 16'hB400, shifts every Clk regardless of state; never 0.
//  Tick: prescaler counts 0..TICK_DIV-1 in WAIT/ACTIVE only; tick=1 in the cycle it equals
//   TICK_DIV-1 (then wraps to 0). Prescaler cleared on every state entry.
//  States:
//   IDLE:   ctrl=0. play_flag=1 -> WAIT (delay_cnt <= DELAY_MIN + (lfsr & DELAY_MASK),
//           sampled on the transition cycle).
//   WAIT:   ctrl=0. On tick: delay_cnt<=1 -> ACTIVE (attack_cnt<=ATTACK_TICKS, ctrl<=1),
//           else delay_cnt-1. Spawn delay = loaded value in ticks exactly.
//   ACTIVE: ctrl=1. btm_kill=1 -> WAIT: ctrl<=0, kill_count+1 (sat), new random delay loaded.
//           Else on tick: attack_cnt<=1 -> HALT with btm_attack_timeout<=1, ctrl<=0;
//           else attack_cnt-1.
//   HALT:   ctrl=0, counters frozen, kill_count held; exit only by Reset.
//  Priority (per cycle): game_stop > btm_kill > tick expiry. game_stop=1 in WAIT/ACTIVE -> HALT
//   next edge, ctrl<=0, timeout not set. game_stop in IDLE ignored.
//  Kill and expiring tick same cycle: kill wins, no timeout.
//  btm_kill outside ACTIVE ignored; a held btm_kill counts once per ACTIVE entry (kills the
//   next monster in its first ACTIVE cycle -> 1-cycle ctrl pulse; allowed).
//  play_flag dropping after IDLE has no effect.
//  ctrl changes only on Clk edges; consumer sees kill effect one cycle after btm_kill sampled.
//  Reset mid-operation: immediate return to reset values, ctrl drops asynchronously.
// TESTING (TICK_DIV=4, DELAY_MIN=2, DELAY_MASK=16'h3, ATTACK_TICKS=5)
//  1 Reset then play_flag=1 -> WAIT; ctrl rises after (2+(lfsr&3))*4 cycles; check vs model LFSR.
//  2 In ACTIVE pulse btm_kill -> ctrl=0 next edge, kill_count=1, WAIT with new random delay.
//  3 No kill -> after exactly 5*4 cycles in ACTIVE: HALT, timeout=1, ctrl=0, held until Reset.
//  4 btm_kill on same cycle as final attack tick -> WAIT, timeout=0, kill_count incremented.
//  5 game_stop in WAIT and in ACTIVE -> HALT next edge, ctrl=0, timeout=0; kill in HALT ignored.
//  6 Hold btm_kill, run 300 spawns -> kill_count saturates at 255; assert Reset mid-ACTIVE ->
//    all outputs 0, state IDLE immediately.

Source files
------------

// File: rtl/nexys_starship_btm_spawner_if.sv
// Bus between the bottom monster spawner and its environment (game control / bottom station).
interface nexys_starship_btm_spawner_if;
   logic       play_flag;
   logic       game_stop;
   logic       btm_kill;
   logic       btm_monster_ctrl;
   logic       btm_attack_timeout;
   logic [7:0] kill_count;
   logic       q_Idle;
   logic       q_Wait;
   logic       q_Active;
   logic       q_Halt;

   // Environment side: drives game controls, observes the spawner
   modport master (
      output play_flag, game_stop, btm_kill,
      input  btm_monster_ctrl, btm_attack_timeout, kill_count,
      input  q_Idle, q_Wait, q_Active, q_Halt
   );

   // Spawner side
   modport slave (
      input  play_flag, game_stop, btm_kill,
      output btm_monster_ctrl, btm_attack_timeout, kill_count,
      output q_Idle, q_Wait, q_Active, q_Halt
   );
endinterface

// File: rtl/nexys_starship_btm_spawner.sv
// Bottom monster spawner: random spawn delay, monster held until killed, timeout if it
// outlives its attack window, permanent halt on timeout or global game stop.
module nexys_starship_btm_spawner #(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned DELAY_MIN    = 1000,
   parameter logic [15:0] DELAY_MASK   = 16'h0FFF,
   parameter int unsigned ATTACK_TICKS = 5000,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input logic                          Clk,
   input logic                          Reset,
   nexys_starship_btm_spawner_if.slave  bus
);

   localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DLY_MAX = DELAY_MIN + 32'(DELAY_MASK);
   localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
   localparam int unsigned ATK_W   = $clog2(ATTACK_TICKS + 1);
   localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] TAPS    = 16'hB400;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   logic [1:0]       r_state,       w_state_nxt;
   logic [15:0]      r_lfsr,        w_lfsr_nxt;
   logic [PRE_W-1:0] r_presc,       w_presc_nxt;
   logic [DLY_W-1:0] r_delay_cnt,   w_delay_nxt;
   logic [ATK_W-1:0] r_attack_cnt,  w_attack_nxt;
   logic             r_timeout,     w_timeout_nxt;
   logic [7:0]       r_kill_count,  w_kill_nxt;
   logic             r_ctrl;
   logic             r_q_idle, r_q_wait, r_q_active, r_q_halt;
   logic             w_tick;
   logic [DLY_W-1:0] w_delay_load;

   // Prescaler terminal count marks one tick
   assign w_tick       = (r_presc == PRE_W'(TICK_DIV - 1));
   // Fresh spawn delay drawn from the current LFSR value
   assign w_delay_load = DLY_W'(DELAY_MIN) + DLY_W'(r_lfsr & DELAY_MASK);
   // Galois LFSR free-runs in every state
   assign w_lfsr_nxt   = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

   // Next-state and counter logic; priority game_stop > btm_kill > tick expiry
   always_comb begin
      w_state_nxt   = r_state;
      w_presc_nxt   = r_presc;
      w_delay_nxt   = r_delay_cnt;
      w_attack_nxt  = r_attack_cnt;
      w_timeout_nxt = r_timeout;
      w_kill_nxt    = r_kill_count;
      case (r_state)
         S_IDLE: begin
            if (bus.play_flag) begin
               w_state_nxt = S_WAIT;
               w_presc_nxt = '0;
               w_delay_nxt = w_delay_load;
            end
         end
         S_WAIT: begin
            if (bus.game_stop) begin
               w_state_nxt = S_HALT;
               w_presc_nxt = '0;
            end else if (w_tick) begin
               w_presc_nxt = '0;
               if (r_delay_cnt <= DLY_W'(1)) begin
                  w_state_nxt  = S_ACTIVE;
                  w_attack_nxt = ATK_W'(ATTACK_TICKS);
               end else begin
                  w_delay_nxt = r_delay_cnt - DLY_W'(1);
               end
            end else begin
               w_presc_nxt = r_presc + PRE_W'(1);
            end
         end
         S_ACTIVE: begin
            if (bus.game_stop) begin
               w_state_nxt = S_HALT;
               w_presc_nxt = '0;
            end else if (bus.btm_kill) begin
               w_state_nxt = S_WAIT;
               w_presc_nxt = '0;
               w_delay_nxt = w_delay_load;
               if (r_kill_count != 8'hFF) w_kill_nxt = r_kill_count + 8'd1;
            end else if (w_tick) begin
               w_presc_nxt = '0;
               if (r_attack_cnt <= ATK_W'(1)) begin
                  w_state_nxt   = S_HALT;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_attack_nxt = r_attack_cnt - ATK_W'(1);
               end
            end else begin
               w_presc_nxt = r_presc + PRE_W'(1);
            end
         end
         default: ;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_lfsr       <= SEED;
         r_presc      <= '0;
         r_delay_cnt  <= '0;
         r_attack_cnt <= '0;
         r_timeout    <= 1'b0;
         r_kill_count <= 8'd0;
         r_ctrl       <= 1'b0;
         r_q_idle     <= 1'b1;
         r_q_wait     <= 1'b0;
         r_q_active   <= 1'b0;
         r_q_halt     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_lfsr       <= w_lfsr_nxt;
         r_presc      <= w_presc_nxt;
         r_delay_cnt  <= w_delay_nxt;
         r_attack_cnt <= w_attack_nxt;
         r_timeout    <= w_timeout_nxt;
         r_kill_count <= w_kill_nxt;
         r_ctrl       <= (w_state_nxt == S_ACTIVE);
         r_q_idle     <= (w_state_nxt == S_IDLE);
         r_q_wait     <= (w_state_nxt == S_WAIT);
         r_q_active   <= (w_state_nxt == S_ACTIVE);
         r_q_halt     <= (w_state_nxt == S_HALT);
      end
   end

   assign bus.btm_monster_ctrl   = r_ctrl;
   assign bus.btm_attack_timeout = r_timeout;
   assign bus.kill_count         = r_kill_count;
   assign bus.q_Idle             = r_q_idle;
   assign bus.q_Wait             = r_q_wait;
   assign bus.q_Active           = r_q_active;
   assign bus.q_Halt             = r_q_halt;

endmodule

// File: tb/tb_nexys_starship_btm_spawner.sv
// Self-checking bench for the bottom monster spawner with small test parameters.
module tb_nexys_starship_btm_spawner;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned DMIN     = 2;
   localparam int unsigned ATK      = 5;
   localparam int unsigned ATK_CYC  = ATK * TICK_DIV;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [15:0] m_lfsr;

   nexys_starship_btm_spawner_if bus ();

   nexys_starship_btm_spawner #(
      .TICK_DIV     (TICK_DIV),
      .DELAY_MIN    (DMIN),
      .DELAY_MASK   (16'h0003),
      .ATTACK_TICKS (ATK),
      .LFSR_SEED    (16'hACE1)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   // Reference random source: 16-bit Galois LFSR, taps B400, steps every clock
   always @(posedge Clk or posedge Reset) begin
      if (Reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   // Spawn delay in clock cycles that the spawner draws in the current cycle
   function automatic int spawn_cycles(input logic [15:0] lf);
      return (int'(DMIN) + int'(lf & 16'h0003)) * int'(TICK_DIV);
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_state(input string tag, input logic [3:0] exp_onehot);
      check(tag, {28'd0, bus.q_Idle, bus.q_Wait, bus.q_Active, bus.q_Halt}, {28'd0, exp_onehot});
   endtask

   // Count cycles until the monster appears; bounded so a stuck DUT cannot hang the run
   task automatic wait_spawn(input string tag, input int exp_n);
      int n;
      n = 0;
      while (bus.btm_monster_ctrl !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check(tag, n, exp_n);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      bus.play_flag = 1'b0;
      bus.game_stop = 1'b0;
      bus.btm_kill  = 1'b0;
      step();
      step();
      Reset = 1'b0;
   endtask

   // Play from IDLE and return once the first monster is up
   task automatic start_and_spawn(input string tag);
      int exp_n;
      bus.play_flag = 1'b1;
      exp_n = spawn_cycles(m_lfsr);
      step();
      bus.play_flag = 1'b0;
      wait_spawn(tag, exp_n);
   endtask

   initial begin
      int k;
      int exp_n;
      int exp_kills;

      // Reset values
      do_reset();
      check("rst_ctrl",    32'(bus.btm_monster_ctrl), 32'd0);
      check("rst_timeout", 32'(bus.btm_attack_timeout), 32'd0);
      check("rst_kills",   32'(bus.kill_count), 32'd0);
      check_state("rst_state", 4'b1000);

      // game_stop while idle is ignored
      bus.game_stop = 1'b1;
      step();
      step();
      check_state("idle_stop_ignored", 4'b1000);
      bus.game_stop = 1'b0;

      // Scenario 1: play -> random spawn delay
      bus.play_flag = 1'b1;
      exp_n = spawn_cycles(m_lfsr);
      step();
      bus.play_flag = 1'b0;
      check_state("s1_wait", 4'b0100);
      check("s1_ctrl_low", 32'(bus.btm_monster_ctrl), 32'd0);
      wait_spawn("s1_spawn_delay", exp_n);
      check_state("s1_active", 4'b0010);

      // Scenario 2: kill pulse at a random point in the attack window
      k = int'($urandom_range(0, ATK_CYC - 2));
      repeat (k) step();
      bus.btm_kill = 1'b1;
      exp_n = spawn_cycles(m_lfsr);
      step();
      bus.btm_kill = 1'b0;
      check("s2_ctrl_drop", 32'(bus.btm_monster_ctrl), 32'd0);
      check("s2_kills",     32'(bus.kill_count), 32'd1);
      check_state("s2_wait", 4'b0100);
      wait_spawn("s2_respawn_delay", exp_n);

      // Scenario 3: monster survives the full attack window
      k = 0;
      while (bus.btm_attack_timeout !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      check("s3_timeout_cycles", k, ATK_CYC);
      check("s3_ctrl", 32'(bus.btm_monster_ctrl), 32'd0);
      check_state("s3_halt", 4'b0001);
      bus.btm_kill  = 1'b1;
      bus.play_flag = 1'b1;
      repeat (12) step();
      bus.btm_kill  = 1'b0;
      bus.play_flag = 1'b0;
      check("s3_timeout_held", 32'(bus.btm_attack_timeout), 32'd1);
      check("s3_kills_held",   32'(bus.kill_count), 32'd1);
      check_state("s3_halt_held", 4'b0001);

      // Scenario 4: kill coincides with the final attack tick
      do_reset();
      start_and_spawn("s4_spawn");
      repeat (ATK_CYC - 1) step();
      bus.btm_kill = 1'b1;
      step();
      bus.btm_kill = 1'b0;
      check_state("s4_wait", 4'b0100);
      check("s4_timeout", 32'(bus.btm_attack_timeout), 32'd0);
      check("s4_kills",   32'(bus.kill_count), 32'd1);

      // Scenario 5a: game_stop during WAIT
      do_reset();
      bus.play_flag = 1'b1;
      exp_n = spawn_cycles(m_lfsr);
      step();
      bus.play_flag = 1'b0;
      k = int'($urandom_range(0, exp_n - 1));
      repeat (k) step();
      bus.game_stop = 1'b1;
      step();
      check_state("s5_wait_halt", 4'b0001);
      check("s5_wait_ctrl", 32'(bus.btm_monster_ctrl), 32'd0);
      check("s5_wait_timeout", 32'(bus.btm_attack_timeout), 32'd0);
      bus.game_stop = 1'b0;
      bus.btm_kill  = 1'b1;
      step();
      bus.btm_kill  = 1'b0;
      step();
      check("s5_halt_kill_ignored", 32'(bus.kill_count), 32'd0);

      // Scenario 5b: game_stop during ACTIVE wins over a simultaneous kill
      do_reset();
      start_and_spawn("s5_spawn");
      k = int'($urandom_range(0, ATK_CYC - 1));
      repeat (k) step();
      bus.game_stop = 1'b1;
      bus.btm_kill  = 1'b1;
      step();
      bus.game_stop = 1'b0;
      bus.btm_kill  = 1'b0;
      check_state("s5_active_halt", 4'b0001);
      check("s5_active_ctrl", 32'(bus.btm_monster_ctrl), 32'd0);
      check("s5_active_timeout", 32'(bus.btm_attack_timeout), 32'd0);
      check("s5_active_kills", 32'(bus.kill_count), 32'd0);

      // Scenario 6: held kill over 300 spawns saturates the kill counter
      do_reset();
      bus.btm_kill = 1'b1;
      start_and_spawn("s6_first_spawn");
      exp_kills = 0;
      for (int i = 1; i < 300; i++) begin
         exp_n = spawn_cycles(m_lfsr);
         step();
         exp_kills = (exp_kills < 255) ? exp_kills + 1 : 255;
         check("s6_kills", 32'(bus.kill_count), 32'(exp_kills));
         wait_spawn("s6_respawn", exp_n);
      end
      check("s6_kills_sat", 32'(bus.kill_count), 32'd255);
      check_state("s6_active", 4'b0010);

      // Asynchronous reset while a monster is up
      Reset = 1'b1;
      #1;
      check("s6_rst_ctrl",    32'(bus.btm_monster_ctrl), 32'd0);
      check("s6_rst_timeout", 32'(bus.btm_attack_timeout), 32'd0);
      check("s6_rst_kills",   32'(bus.kill_count), 32'd0);
      check_state("s6_rst_state", 4'b1000);
      bus.btm_kill = 1'b0;
      step();
      Reset = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
